// File: rtl/game_timer_ctrl.sv
// Countdown game timer: seconds prescaler, pause and bonus handling, expiry pulse, low-time warning.
// Optional build macro GAME_TIMER_BLINK_EN blinks displayEnable at half duty while warning is set.
module game_timer_ctrl #(
  parameter int unsigned CLK_FREQ  = 31500000,
  parameter int unsigned LIMIT_SEC = 999,
  parameter int unsigned WARN_SEC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] loadSeconds,
  input  logic        pause,
  input  logic        addTime,
  input  logic [7:0]  addSeconds,
  output logic [10:0] timeInSeconds,
  output logic        running,
  output logic        expired,
  output logic        timeUp,
  output logic        warning,
  output logic        displayEnable
);

  localparam int unsigned TW = 11;
  localparam int unsigned SW = 12;
  localparam int unsigned PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ - 1);
  localparam logic [SW-1:0] LIMIT_EXT  = SW'(LIMIT_SEC);
`ifdef GAME_TIMER_BLINK_EN
  localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_FREQ / 2);
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] time_q, time_d;
  logic          time_up_q, time_up_d;
  logic          running_q, expired_q;
  logic          warn_q, warn_d;
  logic          disp_q, disp_d;

  logic          tick_c;
  logic [SW-1:0] load_ext;
  logic [TW-1:0] load_sat;
  logic [SW-1:0] upd_sum;
  logic [TW-1:0] upd_sat;

  // Saturating arithmetic; 12-bit sum keeps 2047 + 255 from wrapping.
  always_comb begin
    tick_c   = (state_q == ST_RUNNING) && !pause && (presc_q == PRESC_LAST);
    load_ext = SW'(loadSeconds);
    load_sat = (load_ext > LIMIT_EXT) ? TW'(LIMIT_EXT) : loadSeconds;
    upd_sum  = SW'(time_q) - SW'(tick_c) + (addTime ? SW'(addSeconds) : SW'(0));
    upd_sat  = (upd_sum > LIMIT_EXT) ? TW'(LIMIT_EXT) : TW'(upd_sum);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    time_d    = time_q;
    time_up_d = 1'b0;
    warn_d    = 1'b0;
    disp_d    = 1'b1;

    if (start) begin
      presc_d = '0;
      time_d  = load_sat;
      if (load_sat == '0) begin
        state_d   = ST_EXPIRED;
        time_up_d = 1'b1;
      end else begin
        state_d = ST_RUNNING;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_RUNNING: begin
          if (!pause) begin
            presc_d = tick_c ? '0 : presc_q + PW'(1);
          end
          time_d = upd_sat;
          if (tick_c && (upd_sat == '0)) begin
            state_d   = ST_EXPIRED;
            time_up_d = 1'b1;
          end else if (pause) begin
            state_d = ST_PAUSED;
          end
        end
        ST_PAUSED: begin
          // tick_c is low here, so upd_sat is the value plus any bonus
          time_d = upd_sat;
          if (!pause) begin
            state_d = ST_RUNNING;
          end
        end
        ST_EXPIRED: begin
          time_d = '0;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    warn_d = ((state_d == ST_RUNNING) || (state_d == ST_PAUSED)) &&
             (time_d != '0) && (32'(time_d) <= WARN_SEC);
`ifdef GAME_TIMER_BLINK_EN
    disp_d = !warn_d || (presc_d < PRESC_HALF);
`else
    disp_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      time_q    <= '0;
      time_up_q <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      warn_q    <= 1'b0;
      disp_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      time_q    <= time_d;
      time_up_q <= time_up_d;
      running_q <= (state_d == ST_RUNNING);
      expired_q <= (state_d == ST_EXPIRED);
      warn_q    <= warn_d;
      disp_q    <= disp_d;
    end
  end

  assign timeInSeconds = time_q;
  assign running       = running_q;
  assign expired       = expired_q;
  assign timeUp        = time_up_q;
  assign warning       = warn_q;
  assign displayEnable = disp_q;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Bench for game_timer_ctrl: seconds-level model compared every cycle, plus hand-computed directed checks.
module tb_game_timer_ctrl;

  localparam int CLK_FREQ  = 10;
  localparam int LIMIT_SEC = 999;
  localparam int WARN_SEC  = 10;
  localparam int M_IDLE    = 0;
  localparam int M_RUN     = 1;
  localparam int M_PAUSE   = 2;
  localparam int M_EXP     = 3;
`ifdef GAME_TIMER_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [10:0] loadSeconds = '0;
  logic        pause = 1'b0;
  logic        addTime = 1'b0;
  logic [7:0]  addSeconds = '0;
  logic [10:0] timeInSeconds;
  logic        running, expired, timeUp, warning, displayEnable;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int mode;
    int secs;
    int phase;
    bit pulse;
    bit valid;
  } model_t;

  model_t m = '{M_IDLE, 0, 0, 1'b0, 1'b0};

  game_timer_ctrl #(
    .CLK_FREQ (CLK_FREQ),
    .LIMIT_SEC(LIMIT_SEC),
    .WARN_SEC (WARN_SEC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .loadSeconds  (loadSeconds),
    .pause        (pause),
    .addTime      (addTime),
    .addSeconds   (addSeconds),
    .timeInSeconds(timeInSeconds),
    .running      (running),
    .expired      (expired),
    .timeUp       (timeUp),
    .warning      (warning),
    .displayEnable(displayEnable)
  );

  always #5 clk = ~clk;

  function automatic int lim(int v);
    return (v > LIMIT_SEC) ? LIMIT_SEC : v;
  endfunction

  // One game clock of the timer rules, applied to the model.
  function automatic model_t step(model_t c, logic rst, logic st, logic [10:0] ld,
                                  logic ps, logic ad, logic [7:0] add_s);
    model_t n;
    bit     tick;
    n       = c;
    tick    = 1'b0;
    n.pulse = 1'b0;
    if (rst) begin
      n.mode  = M_IDLE;
      n.secs  = 0;
      n.phase = 0;
      n.valid = 1'b1;
    end else if (!c.valid) begin
      n = c;
    end else if (st) begin
      n.secs  = lim(int'(ld));
      n.phase = 0;
      if (n.secs == 0) begin
        n.mode  = M_EXP;
        n.pulse = 1'b1;
      end else begin
        n.mode = M_RUN;
      end
    end else if (c.mode == M_RUN) begin
      tick = !ps && (c.phase == CLK_FREQ - 1);
      if (!ps) n.phase = (c.phase + 1) % CLK_FREQ;
      n.secs = lim(c.secs - (tick ? 1 : 0) + (ad ? int'(add_s) : 0));
      if (tick && n.secs == 0) begin
        n.mode  = M_EXP;
        n.pulse = 1'b1;
      end else if (ps) begin
        n.mode = M_PAUSE;
      end
    end else if (c.mode == M_PAUSE) begin
      if (ad) n.secs = lim(c.secs + int'(add_s));
      if (!ps) n.mode = M_RUN;
    end
    return n;
  endfunction

  function automatic logic [15:0] expv(model_t c);
    bit warn;
    bit disp;
    warn = (c.mode == M_RUN || c.mode == M_PAUSE) && c.secs > 0 && c.secs <= WARN_SEC;
    disp = !(BLINK && warn) || (c.phase < CLK_FREQ / 2);
    return {11'(c.secs), c.mode == M_RUN, c.mode == M_EXP, c.pulse, warn, disp};
  endfunction

  initial forever begin
    @(posedge clk);
    m = step(m, reset, start, loadSeconds, pause, addTime, addSeconds);
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    logic [15:0] act_v;
    logic [15:0] exp_v;
    @(negedge clk);
    act_v = {timeInSeconds, running, expired, timeUp, warning, displayEnable};
    exp_v = expv(m);
    if (m.valid) begin
      tests++;
      if (act_v !== exp_v) begin
        fails++;
        $display("FAIL cycle_compare t=%0t time=%0d exp %0d run=%b exp %b expired=%b exp %b timeUp=%b exp %b warning=%b exp %b disp=%b exp %b",
                 $time, act_v[15:5], exp_v[15:5], act_v[4], exp_v[4], act_v[3], exp_v[3],
                 act_v[2], exp_v[2], act_v[1], exp_v[1], act_v[0], exp_v[0]);
      end
    end
  end

  task automatic chk(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic do_start(int v);
    start       = 1'b1;
    loadSeconds = 11'(v);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_add(int v);
    addTime    = 1'b1;
    addSeconds = 8'(v);
    @(negedge clk);
    addTime = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_time", int'(timeInSeconds), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_expired", int'(expired), 0);
    chk("rst_timeup", int'(timeUp), 0);
    chk("rst_warning", int'(warning), 0);
    chk("rst_disp", int'(displayEnable), 1);
    reset = 1'b0;

    do_add(50);
    chk("idle_add_ignored", int'(timeInSeconds), 0);

    // 3-second countdown at 10 cycles per second
    do_start(3);
    chk("cd_load", int'(timeInSeconds), 3);
    chk("cd_running", int'(running), 1);
    repeat (10) @(negedge clk);
    chk("cd_2", int'(timeInSeconds), 2);
    repeat (10) @(negedge clk);
    chk("cd_1", int'(timeInSeconds), 1);
    repeat (9) @(negedge clk);
    chk("cd_1_late", int'(timeInSeconds), 1);
    chk("cd_no_early_timeup", int'(timeUp), 0);
    @(negedge clk);
    chk("cd_0", int'(timeInSeconds), 0);
    chk("cd_timeup", int'(timeUp), 1);
    chk("cd_expired", int'(expired), 1);
    @(negedge clk);
    chk("cd_timeup_once", int'(timeUp), 0);
    chk("cd_expired_hold", int'(expired), 1);

    // Saturation at LIMIT_SEC
    do_start(2047);
    chk("sat_load", int'(timeInSeconds), 999);
    do_add(255);
    chk("sat_add", int'(timeInSeconds), 999);

    // Zero load expires immediately; bonus ignored while expired
    do_start(0);
    chk("zero_time", int'(timeInSeconds), 0);
    chk("zero_expired", int'(expired), 1);
    chk("zero_timeup", int'(timeUp), 1);
    @(negedge clk);
    chk("zero_timeup_once", int'(timeUp), 0);
    do_add(20);
    chk("exp_add_ignored", int'(timeInSeconds), 0);

    // Warning window and blink phase
    do_start(10);
    chk("warn_on", int'(warning), 1);
    for (int k = 0; k < 10; k++) begin
      chk("warn_disp", int'(displayEnable), (BLINK && k >= 5) ? 0 : 1);
      @(negedge clk);
    end
    chk("warn_9", int'(timeInSeconds), 9);

    // Pause for 37 cycles at prescaler 4
    do_start(20);
    repeat (4) @(negedge clk);
    pause = 1'b1;
    repeat (37) @(negedge clk);
    chk("pause_hold", int'(timeInSeconds), 20);
    chk("pause_not_running", int'(running), 0);
    pause = 1'b0;
    repeat (6) @(negedge clk);
    chk("resume_pre_tick", int'(timeInSeconds), 20);
    chk("resume_running", int'(running), 1);
    @(negedge clk);
    chk("resume_tick", int'(timeInSeconds), 19);

    // Bonus on the tick that would have expired the timer
    do_start(1);
    repeat (9) @(negedge clk);
    do_add(5);
    chk("tick_add_time", int'(timeInSeconds), 5);
    chk("tick_add_no_timeup", int'(timeUp), 0);
    chk("tick_add_running", int'(running), 1);

    // Reset mid-count
    do_start(7);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_time", int'(timeInSeconds), 0);
    chk("midrst_running", int'(running), 0);
    chk("midrst_timeup", int'(timeUp), 0);
    chk("midrst_warning", int'(warning), 0);
    chk("midrst_disp", int'(displayEnable), 1);

    // Randomized traffic, checked by the per-cycle compare
    for (int i = 0; i < 3000; i++) begin
      start       = ($urandom_range(0, 39) == 0);
      loadSeconds = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 2047))
                                                : 11'($urandom_range(0, 12));
      addTime     = ($urandom_range(0, 14) == 0);
      addSeconds  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      if ($urandom_range(0, 19) == 0) pause = !pause;
      reset       = ($urandom_range(0, 599) == 0);
      @(negedge clk);
    end
    start   = 1'b0;
    addTime = 1'b0;
    reset   = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
